// File: rtl/udp_rx_ctrl_pkg.sv
// udp_rx_ctrl shared constants, state encoding and byte helper.
// Lengths are shared with the transmit-side controller.
package udp_rx_ctrl_pkg;

  localparam logic [15:0] FREQ_LEN = 16'd2;
  localparam int DATA_LEN_DEF = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    DATA  = 2'd2,
    DRAIN = 2'd3
  } rx_state_t;

  function automatic logic [7:0] byte_of(
    input logic [31:0] w,
    input logic [1:0]  i
  );
    logic [7:0] b;
    unique case (i)
      2'd0: b = w[31:24];
      2'd1: b = w[23:16];
      2'd2: b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/udp_rx_ctrl_byte_ser.sv
// udp_rx_byte_ser: 2-word queue emitting one byte per cycle, MSB first.
// An empty queue forwards a pushed word straight to the byte output.
module udp_rx_byte_ser
  import udp_rx_ctrl_pkg::*;
(
  input  logic        clk_125m,
  input  logic        rst_n,
  input  logic        push,
  input  logic [31:0] push_data,
  output logic        empty,
  output logic        byte_vld,
  output logic [7:0]  byte_data
);

  logic [31:0] q0;
  logic [31:0] q1;
  logic [1:0]  cnt;
  logic [1:0]  idx;
  logic [31:0] head;
  logic        pop;

  assign empty     = (cnt == 2'd0);
  assign head      = empty ? push_data : q0;
  assign byte_vld  = ~empty | push;
  assign byte_data = byte_of(head, idx);
  assign pop       = byte_vld & (idx == 2'd3);

  always_ff @(posedge clk_125m or negedge rst_n) begin
    if (!rst_n) begin
      q0  <= '0;
      q1  <= '0;
      cnt <= '0;
      idx <= '0;
    end else begin
      if (byte_vld)
        idx <= idx + 2'd1;
      unique case (cnt)
        2'd0: begin
          if (push) begin
            q0  <= push_data;
            cnt <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            q0 <= push_data;
          end else if (pop) begin
            cnt <= 2'd0;
          end else if (push) begin
            q1  <= push_data;
            cnt <= 2'd2;
          end
        end
        2'd2: begin
          if (pop) begin
            q0 <= q1;
            if (push)
              q1 <= push_data;
            else
              cnt <= 2'd1;
          end
        end
        default: cnt <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/udp_rx_ctrl.sv
// udp_rx_ctrl: classifies UDP rx packets by length into
// frequency updates, FIFO sample bytes or length errors.
module udp_rx_ctrl
  import udp_rx_ctrl_pkg::*;
#(
  parameter int DATA_LEN = DATA_LEN_DEF
) (
  input  logic        clk_125m,
  input  logic        rst_n,
  input  logic        rec_en,
  input  logic [31:0] rec_data,
  input  logic        rec_pkt_done,
  input  logic [15:0] rec_byte_num,
  input  logic        fifo_full,
  output logic        wr_en,
  output logic [7:0]  wr_data,
  output logic [15:0] wave_freq,
  output logic        freq_valid,
  output logic        rx_busy,
  output logic        len_err,
  output logic        ovf_err
);

  localparam logic [15:0] WORDS = 16'(DATA_LEN / 4);
  localparam logic [15:0] DLEN  = 16'(DATA_LEN);

  rx_state_t   state;
  rx_state_t   state_nxt;
  logic [31:0] hold;
  logic        pend;
  logic [15:0] wcnt;
  logic        done_q;
  logic [15:0] bn_q;
  logic        rx_done;
  logic [15:0] rx_bn;
  logic        ser_push;
  logic [31:0] ser_data;
  logic        ser_empty;
  logic        ser_vld;
  logic [7:0]  ser_byte;
  logic        hold_ld;
  logic        freq_ld;
  logic        len_err_d;

  // A done colliding with a word is replayed one cycle later.
  assign rx_done = (rec_pkt_done & ~rec_en) | done_q;
  assign rx_bn   = done_q ? bn_q : rec_byte_num;
  assign rx_busy = (state != IDLE);

  always_ff @(posedge clk_125m or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (rec_en) state_nxt = HOLD;
      HOLD: begin
        if (rec_en)
          state_nxt = DATA;
        else if (rx_done)
          state_nxt = IDLE;
      end
      DATA:  if (rx_done) state_nxt = DRAIN;
      DRAIN: if (ser_empty && !pend) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ser_push  = 1'b0;
    ser_data  = rec_data;
    hold_ld   = 1'b0;
    freq_ld   = 1'b0;
    len_err_d = 1'b0;
    unique case (state)
      IDLE: begin
        hold_ld   = rec_en;
        len_err_d = rx_done;
      end
      HOLD: begin
        if (rec_en) begin
          ser_push = 1'b1;
          ser_data = hold;
          hold_ld  = 1'b1;
        end else if (rx_done) begin
          freq_ld   = (rx_bn == FREQ_LEN);
          len_err_d = (rx_bn != FREQ_LEN);
        end
      end
      DATA: begin
        if (pend) begin
          ser_push = 1'b1;
          ser_data = hold;
        end else if (rec_en && wcnt < WORDS) begin
          ser_push = 1'b1;
        end
        len_err_d = rx_done && (rx_bn != DLEN);
      end
      default: ;
    endcase
  end

  // Second word is parked in hold and pushed on the following cycle.
  always_ff @(posedge clk_125m or negedge rst_n) begin
    if (!rst_n) begin
      hold   <= '0;
      pend   <= 1'b0;
      wcnt   <= '0;
      done_q <= 1'b0;
      bn_q   <= '0;
    end else begin
      if (hold_ld)
        hold <= rec_data;
      pend   <= (state == HOLD) && rec_en && (WORDS > 16'd1);
      done_q <= rec_en & rec_pkt_done;
      bn_q   <= rec_byte_num;
      if (state == IDLE && rec_en)
        wcnt <= '0;
      else if (state == HOLD && rec_en)
        wcnt <= (WORDS > 16'd1) ? 16'd2 : 16'd1;
      else if (state == DATA && ser_push && !pend)
        wcnt <= wcnt + 16'd1;
    end
  end

  always_ff @(posedge clk_125m or negedge rst_n) begin
    if (!rst_n) begin
      wr_en      <= 1'b0;
      wr_data    <= '0;
      ovf_err    <= 1'b0;
      len_err    <= 1'b0;
      freq_valid <= 1'b0;
      wave_freq  <= '0;
    end else begin
      wr_en      <= ser_vld & ~fifo_full;
      ovf_err    <= ser_vld & fifo_full;
      len_err    <= len_err_d;
      freq_valid <= freq_ld;
      if (ser_vld)
        wr_data <= ser_byte;
      if (freq_ld)
        wave_freq <= {hold[23:16], hold[31:24]};
    end
  end

  udp_rx_byte_ser u_ser (
    .clk_125m  (clk_125m),
    .rst_n     (rst_n),
    .push      (ser_push),
    .push_data (ser_data),
    .empty     (ser_empty),
    .byte_vld  (ser_vld),
    .byte_data (ser_byte)
  );

endmodule

// File: tb/tb_udp_rx_ctrl.sv
// tb_udp_rx_ctrl: scenario tasks with a byte scoreboard
// checking FIFO writes, frequency decode and error pulses.
module tb_udp_rx_ctrl;
  import udp_rx_ctrl_pkg::*;

  localparam int WORDS = DATA_LEN_DEF / 4;

  logic        clk_125m = 1'b0;
  logic        rst_n = 1'b0;
  logic        rec_en = 1'b0;
  logic [31:0] rec_data = '0;
  logic        rec_pkt_done = 1'b0;
  logic [15:0] rec_byte_num = '0;
  logic        fifo_full = 1'b0;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic [15:0] wave_freq;
  logic        freq_valid;
  logic        rx_busy;
  logic        len_err;
  logic        ovf_err;

  int errors = 0;
  int checks = 0;
  int wr_cnt, ovf_cnt, len_cnt, fv_cnt;
  bit sb_on = 1'b1;
  logic [7:0] exp_q[$];

  udp_rx_ctrl dut (
    .clk_125m     (clk_125m),
    .rst_n        (rst_n),
    .rec_en       (rec_en),
    .rec_data     (rec_data),
    .rec_pkt_done (rec_pkt_done),
    .rec_byte_num (rec_byte_num),
    .fifo_full    (fifo_full),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .wave_freq    (wave_freq),
    .freq_valid   (freq_valid),
    .rx_busy      (rx_busy),
    .len_err      (len_err),
    .ovf_err      (ovf_err)
  );

  always #4 clk_125m = ~clk_125m;

  function automatic logic [31:0] dword(input int w);
    return {8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)};
  endfunction

  task automatic tick();
    logic [7:0] e;
    @(posedge clk_125m);
    #1;
    if (wr_en) begin
      wr_cnt++;
      if (sb_on) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL wr_extra: got %h, expected no write", wr_data);
        end else begin
          e = exp_q.pop_front();
          if (wr_data !== e) begin
            errors++;
            $display("FAIL wr_data: got %h, expected %h", wr_data, e);
          end
        end
      end
    end
    if (ovf_err) ovf_cnt++;
    if (len_err) len_cnt++;
    if (freq_valid) fv_cnt++;
  endtask

  task automatic send(
    input int          nw,
    input logic [15:0] bn,
    input logic [31:0] w0,
    input int          flo,
    input int          fhi,
    input bit          exp_fv,
    input bit          exp_le
  );
    int c_done, c_end, npush, exp_wr, exp_ovf, first_c, k;
    c_done  = 4 * (nw - 1) + 2;
    c_end   = c_done + 40;
    npush   = (nw >= 2) ? ((nw < WORDS) ? nw : WORDS) : 0;
    exp_wr  = 0;
    exp_ovf = 0;
    first_c = -1;
    for (int w = 0; w < npush; w++) begin
      for (int j = 0; j < 4; j++) begin
        k = 4 * w + j;
        if (k >= flo && k <= fhi) begin
          exp_ovf++;
        end else begin
          exp_q.push_back(8'(k));
          exp_wr++;
        end
      end
    end
    wr_cnt = 0; ovf_cnt = 0; len_cnt = 0; fv_cnt = 0;
    for (int c = 0; c <= c_end; c++) begin
      rec_en       = (c % 4 == 0) && (c / 4 < nw);
      rec_data     = (nw == 1) ? w0 : dword(c / 4);
      rec_pkt_done = (c == c_done);
      rec_byte_num = bn;
      fifo_full    = (c >= flo + 4) && (c <= fhi + 4);
      tick();
      if (wr_en && first_c < 0) first_c = c;
      if (c == c_done) begin
        checks++;
        if (freq_valid !== exp_fv || len_err !== exp_le) begin
          errors++;
          $display("FAIL done_pulse: fv=%b le=%b, expected fv=%b le=%b",
                   freq_valid, len_err, exp_fv, exp_le);
        end
      end
    end
    rec_en = 1'b0; rec_pkt_done = 1'b0; fifo_full = 1'b0;
    checks++;
    if (wr_cnt !== exp_wr) begin
      errors++;
      $display("FAIL wr_count: got %0d, expected %0d", wr_cnt, exp_wr);
    end
    checks++;
    if (ovf_cnt !== exp_ovf) begin
      errors++;
      $display("FAIL ovf_count: got %0d, expected %0d", ovf_cnt, exp_ovf);
    end
    checks++;
    if (len_cnt !== int'(exp_le) || fv_cnt !== int'(exp_fv)) begin
      errors++;
      $display("FAIL pulse_count: le=%0d fv=%0d, expected le=%0d fv=%0d",
               len_cnt, fv_cnt, exp_le, exp_fv);
    end
    checks++;
    if (rx_busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: busy=%b left=%0d, expected busy=0 left=0",
               rx_busy, exp_q.size());
    end
    if (npush > 0) begin
      checks++;
      if (first_c !== 4) begin
        errors++;
        $display("FAIL first_byte: cycle %0d, expected 4", first_c);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({wr_en, wr_data, freq_valid, rx_busy, len_err, ovf_err} !== 13'd0) begin
      errors++;
      $display("FAIL reset_out: got wr=%b d=%h fv=%b busy=%b le=%b ov=%b, expected 0",
               wr_en, wr_data, freq_valid, rx_busy, len_err, ovf_err);
    end
    checks++;
    if (wave_freq !== 16'h0000) begin
      errors++;
      $display("FAIL reset_freq: got %h, expected 0000", wave_freq);
    end
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_freq();
    send(1, 16'd2, 32'h3412_abcd, -1, -2, 1'b1, 1'b0);
    checks++;
    if (wave_freq !== 16'h1234) begin
      errors++;
      $display("FAIL freq_val: got %h, expected 1234", wave_freq);
    end
  endtask

  task automatic test_data();
    send(WORDS, 16'(DATA_LEN_DEF), '0, -1, -2, 1'b0, 1'b0);
  endtask

  task automatic test_len_err();
    send(1, 16'd3, 32'h5678_0000, -1, -2, 1'b0, 1'b1);
    checks++;
    if (wave_freq !== 16'h1234) begin
      errors++;
      $display("FAIL freq_keep: got %h, expected 1234", wave_freq);
    end
  endtask

  task automatic test_short_long();
    send(5, 16'd20, '0, -1, -2, 1'b0, 1'b1);
    send(WORDS + 4, 16'(DATA_LEN_DEF + 16), '0, -1, -2, 1'b0, 1'b1);
  endtask

  task automatic test_ovf();
    send(WORDS, 16'(DATA_LEN_DEF), '0, 10, 19, 1'b0, 1'b0);
  endtask

  task automatic test_mid_reset();
    sb_on = 1'b0;
    for (int c = 0; c < 4 * 100 + 2; c++) begin
      rec_en   = (c % 4 == 0);
      rec_data = dword(c / 4);
      tick();
    end
    rec_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    checks++;
    if ({wr_en, wr_data, freq_valid, rx_busy, len_err, ovf_err} !== 13'd0 ||
        wave_freq !== 16'h0000) begin
      errors++;
      $display("FAIL mid_reset: wr=%b d=%h fv=%b busy=%b le=%b ov=%b f=%h, expected 0",
               wr_en, wr_data, freq_valid, rx_busy, len_err, ovf_err, wave_freq);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    exp_q.delete();
    sb_on = 1'b1;
    repeat (20) tick();
    send(1, 16'd2, 32'hc800_5555, -1, -2, 1'b1, 1'b0);
    checks++;
    if (wave_freq !== 16'h00c8) begin
      errors++;
      $display("FAIL freq_after_rst: got %h, expected 00c8", wave_freq);
    end
  endtask

  initial begin
    test_reset();
    test_freq();
    test_data();
    test_len_err();
    test_short_long();
    test_ovf();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/udp_rx_ctrl.md
# udp_rx_ctrl

Receive-side counterpart of the UDP transmit controller. It sits after the UDP receive module in the `clk_125m` domain and classifies each received UDP packet by length. A 2-byte packet updates the frequency word. A `DATA_LEN`-byte packet is serialized from 32-bit words into bytes and written into the sample FIFO. Any other length is flagged.

## Interface
- `DATA_LEN`, default 1024: payload bytes of a sample packet. Must be a multiple of 4 and at most 65532.
- `FREQ_LEN`, default 2: payload bytes of a frequency packet. Fixed value, not tunable.
- `clk_125m`  in  1  system clock; all logic is single-clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rec_en`  in  1  one-cycle pulse marking one valid payload word on `rec_data`.
- `rec_data`  in  32  payload word; `[31:24]` is the first byte on the wire.
- `rec_pkt_done`  in  1  one-cycle end-of-packet pulse.
- `rec_byte_num`  in  16  payload byte count; valid in the `rec_pkt_done` cycle.
- `fifo_full`  in  1  sample FIFO full flag.
- `wr_en`  out  1  FIFO write strobe.
- `wr_data`  out  8  FIFO write byte.
- `wave_freq`  out  16  last received frequency word.
- `freq_valid`  out  1  one-cycle pulse when `wave_freq` updates.
- `rx_busy`  out  1  high while not in IDLE.
- `len_err`  out  1  one-cycle pulse when a packet length is neither `FREQ_LEN` nor `DATA_LEN`.
- `ovf_err`  out  1  one-cycle pulse per byte dropped because `fifo_full` was high.

## Operation
- Input guarantees from the UDP receive module:
  - `rec_en` pulses are at least 4 cycles apart.
  - `rec_pkt_done` comes at least 1 cycle after the last `rec_en` of its packet.
  - The next packet's first `rec_en` comes at least 16 cycles after `rec_pkt_done`.
- **IDLE**
  - On `rec_en`: latch `rec_data` into the hold register, clear the word counter, go to HOLD.
  - A `rec_pkt_done` with no prior `rec_en` is a zero-length packet: pulse `len_err`, stay in IDLE.
- **HOLD** (first word latched; packet type not yet known)
  - `rec_pkt_done` with `rec_byte_num == FREQ_LEN`:
    - `wave_freq[7:0] <= hold[31:24]` and `wave_freq[15:8] <= hold[23:16]`.
    - Pulse `freq_valid`, go to IDLE.
  - `rec_pkt_done` with any other count: pulse `len_err`, discard the hold word, go to IDLE.
  - `rec_en`: push the hold word, then the new word, into the serializer; go to DATA.
- **DATA**
  - Each `rec_en` pushes its word into the serializer while words pushed < `DATA_LEN/4`. Further words are discarded silently.
  - On `rec_pkt_done`: pulse `len_err` if `rec_byte_num != DATA_LEN`, then go to DRAIN.
  - Bytes already written to the FIFO are never retracted.
- **DRAIN**
  - Wait until the serializer is empty, then go to IDLE.
- **Serializer**
  - 2-word queue; emits one byte per cycle, `[31:24]` first.
  - Each emitted byte gives `wr_en = ~fifo_full` and `wr_data = byte`.
  - If `fifo_full` is high, the byte is consumed anyway and `ovf_err` pulses.
  - The queue cannot overflow under the input guarantees.
- `rx_busy` is 1 in HOLD, DATA and DRAIN.
- A `rec_en` and `rec_pkt_done` in the same cycle violate the input guarantee. Required handling: the word is processed first, then the done is evaluated in the next state.

## Timing
- Reset values: all outputs 0 (`wave_freq` = 16'h0000); state IDLE; serializer empty.
- Reset mid-packet clears everything immediately. The rest of the interrupted packet is then handled as a fresh packet, which ends in `len_err` or a discard.
- `freq_valid` is asserted in the cycle after `rec_pkt_done`; `wave_freq` changes in that same cycle.
- First data word: its 4 bytes appear on `wr_en` in cycles N+1..N+4, where N is the cycle of the second `rec_en`. The second word's bytes follow in N+5..N+8.
- Every later word: bytes appear in cycles R+1..R+4, where R is its `rec_en` cycle (when the queue is empty).
- `wr_en` and `wr_data` are registered outputs.
- `len_err` is asserted in the cycle after `rec_pkt_done`.
- `ovf_err` is asserted in the same cycle the byte would have been written.

## Structure
- Shared header `udp_defines.vh` holds:
  - `FREQ_LEN` and the default `DATA_LEN` (shared with the transmit controller).
  - State encodings IDLE=0, HOLD=1, DATA=2, DRAIN=3.
- Sub-module `udp_rx_byte_ser`:
  - 2-entry 32-bit queue plus a byte index.
  - Ports: push, push_data, empty, byte_vld, byte.

## Test plan
- Packet of 1 word 32'h3412_xxxx, `rec_byte_num` = 2 -> `freq_valid` 1 cycle after done; `wave_freq` = 16'h1234; no `wr_en`.
- 256 words, incrementing bytes 0x00..0xFF repeated, `rec_byte_num` = 1024 -> exactly 1024 `wr_en` pulses with bytes in wire order; no `len_err`; `rx_busy` low after DRAIN.
- 1-word packet with `rec_byte_num` = 3 -> `len_err` pulse; `wave_freq` unchanged; no `wr_en`.
- 260-word packet with `rec_byte_num` = 1040 -> 1024 writes, then one `len_err`.
- `fifo_full` held high for bytes 10..19 of a data packet -> 10 `ovf_err` pulses; 1014 writes.
- Reset asserted after word 100 of a data packet -> all outputs 0 at once; a following freq packet with value 16'h00C8 is decoded correctly.
